// File: rtl/uu_acmac_sta_ba_ctrl_if.sv
// uu_acmac_sta_ba_ctrl_if: BA scoreboard request/response handshake plus BA memory port
interface uu_acmac_sta_ba_ctrl_if #(parameter int STA_W = 8);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_cmd;
  logic [STA_W-1:0] req_sta;
  logic [11:0]      req_seq;
  logic             rsp_valid;
  logic [1:0]       rsp_status;
  logic [11:0]      rsp_ssn;
  logic [63:0]      rsp_bitmap;
  logic             mem_tx_in_en;
  logic [3:0]       mem_tx_in_wen;
  logic [13:0]      mem_tx_in_addr;
  logic [31:0]      mem_tx_in_data;
  logic [31:0]      mem_tx_out_data;
  modport master (
    output req_valid, req_cmd, req_sta, req_seq, mem_tx_out_data,
    input  req_ready, rsp_valid, rsp_status, rsp_ssn, rsp_bitmap,
           mem_tx_in_en, mem_tx_in_wen, mem_tx_in_addr, mem_tx_in_data
  );
  modport slave (
    input  req_valid, req_cmd, req_sta, req_seq, mem_tx_out_data,
    output req_ready, rsp_valid, rsp_status, rsp_ssn, rsp_bitmap,
           mem_tx_in_en, mem_tx_in_wen, mem_tx_in_addr, mem_tx_in_data
  );
endinterface

// File: rtl/uu_acmac_sta_ba_ctrl.sv
// uu_acmac_sta_ba_ctrl: per-station block-ack scoreboard memory master (SET_BIT / READ / INIT)
module uu_acmac_sta_ba_ctrl #(
  parameter int STA_W       = 8,
  parameter int ENTRY_WORDS = 4,
  parameter int BASE_ADDR   = 0
) (
  input logic                clk,
  input logic                rst,
  uu_acmac_sta_ba_ctrl_if.slave bus
);
  localparam logic [1:0] SET = 2'b00, RD = 2'b01, INI = 2'b10;
  localparam logic [1:0] OK = 2'b00, OUT_WIN = 2'b01, NOT_INIT = 2'b10, BAD_CMD = 2'b11;
  typedef enum logic [2:0] {IDLE, C1, C2, C3, RSP} state_t;
  state_t           state, st;
  logic [1:0]       cmd, stat, status_q;
  logic [13:0]      base;
  logic [11:0]      seq, ssn, off, ssn_q;
  logic [5:0]       boff;
  logic             set_ok, hit;
  logic [31:0]      hdr, lo;
  logic [63:0]      bitmap_q;
  logic [STA_W-1:0] sta_in;
  // rst forces the idle decode so the memory port is harmless during reset
  assign st     = rst ? IDLE : state;
  assign hdr    = bus.mem_tx_out_data;
  assign sta_in = bus.req_sta;
  assign off    = seq - hdr[11:0];
  assign hit    = hdr[31] && off < 12'd64;
  assign bus.req_ready  = st == IDLE;
  assign bus.rsp_valid  = st == RSP;
  assign bus.rsp_status = status_q;
  assign bus.rsp_ssn    = ssn_q;
  assign bus.rsp_bitmap = st == RSP && cmd == RD ? {hdr, lo} : bitmap_q;
  // SET_BIT addresses and write data follow the live read word, so the port is decoded per cycle
  always_comb begin
    bus.mem_tx_in_en   = 1'b1;
    bus.mem_tx_in_wen  = 4'h0;
    bus.mem_tx_in_addr = 14'd0;
    bus.mem_tx_in_data = 32'd0;
    if (st == C1) begin
      bus.mem_tx_in_addr = base;
      bus.mem_tx_in_wen  = cmd == INI ? 4'hF : 4'h0;
      bus.mem_tx_in_data = cmd == INI ? {1'b1, 19'b0, seq} : 32'd0;
    end else if (st == C2 && (cmd != SET || hit)) begin
      bus.mem_tx_in_addr = base + 14'd1 + {13'd0, cmd == SET && off[5]};
      bus.mem_tx_in_en   = cmd != INI;
    end else if (st == C3 && (cmd != SET || set_ok)) begin
      bus.mem_tx_in_addr = base + (cmd == SET ? 14'd1 + {13'd0, boff[5]} : 14'd2);
      bus.mem_tx_in_en   = cmd != INI;
      bus.mem_tx_in_wen  = cmd == SET ? 4'hF : 4'h0;
      bus.mem_tx_in_data = cmd == SET ? hdr | (32'd1 << boff[4:0]) : 32'd0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      cmd      <= 2'b00;
      base     <= 14'd0;
      seq      <= 12'd0;
      ssn      <= 12'd0;
      boff     <= 6'd0;
      set_ok   <= 1'b0;
      stat     <= OK;
      lo       <= 32'd0;
      status_q <= OK;
      ssn_q    <= 12'd0;
      bitmap_q <= 64'd0;
    end else
      case (state)
        IDLE: if (bus.req_valid) begin
          cmd   <= bus.req_cmd;
          seq   <= bus.req_seq;
          base  <= 14'(BASE_ADDR + ENTRY_WORDS * int'(sta_in));
          state <= &bus.req_cmd ? RSP : C1;
          if (&bus.req_cmd) status_q <= BAD_CMD;
        end
        C1: state <= C2;
        C2: begin
          state  <= C3;
          ssn    <= hdr[11:0];
          boff   <= off[5:0];
          set_ok <= hit;
          stat   <= !hdr[31] ? NOT_INIT : cmd == SET && !hit ? OUT_WIN : OK;
        end
        C3: begin
          state    <= RSP;
          lo       <= hdr;
          status_q <= cmd == INI ? OK : stat;
          ssn_q    <= cmd == INI ? seq : ssn;
        end
        RSP: begin
          state <= IDLE;
          if (cmd == RD) bitmap_q <= {hdr, lo};
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_uu_acmac_sta_ba_ctrl.sv
// tb_uu_acmac_sta_ba_ctrl: directed bench driving the BA controller against a behavioural BA memory
module tb_uu_acmac_sta_ba_ctrl;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  always #5 clk = ~clk;
  uu_acmac_sta_ba_ctrl_if #(.STA_W(8)) bus ();
  uu_acmac_sta_ba_ctrl #(.STA_W(8), .ENTRY_WORDS(4), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:1023];
  logic [31:0] rd;
  logic [9:0]  a;
  assign a = bus.mem_tx_in_addr[9:0];
  assign bus.mem_tx_out_data = rd;
  always @(posedge clk)
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[13] <= 32'hDEADBEEF;
      mem[14] <= 32'hCAFEF00D;
      rd <= 32'h0;
    end else begin
      if (!bus.mem_tx_in_en) mem[a] <= 32'h0;
      else for (int b = 0; b < 4; b++) if (bus.mem_tx_in_wen[b]) mem[a][8*b +: 8] <= bus.mem_tx_in_data[8*b +: 8];
      rd <= bus.mem_tx_in_en ? mem[a] : 32'h0;
    end
  int checks = 0, errors = 0;
  int lat, acc, rsps;
  logic [1:0]  r_st;
  logic [11:0] r_ssn;
  logic [63:0] r_bm;
  logic [7:0]  en_m, wen_m;
  logic        seen;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // one command: latency in cycles after accept, response fields, per-cycle en-low/wen masks
  task automatic run(input logic [1:0] c, input logic [7:0] s, input logic [11:0] q);
    bus.req_cmd = c; bus.req_sta = s; bus.req_seq = q; bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    lat = 0; en_m = 8'h0; wen_m = 8'h0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      en_m[k]  = !bus.mem_tx_in_en;
      wen_m[k] = |bus.mem_tx_in_wen;
      if (bus.rsp_valid) begin
        lat = k; r_st = bus.rsp_status; r_ssn = bus.rsp_ssn; r_bm = bus.rsp_bitmap;
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = 2'b00; bus.req_sta = 8'd0; bus.req_seq = 12'd0;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_en", bus.mem_tx_in_en, 1);
    chk("rst_wen", bus.mem_tx_in_wen, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("idle_status", bus.rsp_status, 0);
    chk("idle_ssn", bus.rsp_ssn, 0);
    chk("idle_bitmap", bus.rsp_bitmap, 0);
    chk("idle_addr", bus.mem_tx_in_addr, 0);
    chk("idle_data", bus.mem_tx_in_data, 0);
    @(posedge clk); #1;
    run(2'b10, 8'd3, 12'h100);
    chk("init_lat", lat, 4);
    chk("init_status", r_st, 0);
    chk("init_en_low", en_m, 8'h0C);
    chk("init_wen", wen_m, 8'h02);
    chk("init_w12", mem[12], 32'h80000100);
    chk("init_w13", mem[13], 32'h0);
    chk("init_w14", mem[14], 32'h0);
    run(2'b00, 8'd3, 12'h105);
    chk("set105_lat", lat, 4);
    chk("set105_status", r_st, 0);
    chk("set105_ssn", r_ssn, 12'h100);
    chk("set105_wen", wen_m, 8'h08);
    run(2'b00, 8'd3, 12'h125);
    chk("set125_status", r_st, 0);
    chk("set125_w14", mem[14], 32'h20);
    run(2'b01, 8'd3, 12'h000);
    chk("read_lat", lat, 4);
    chk("read_status", r_st, 0);
    chk("read_ssn", r_ssn, 12'h100);
    chk("read_bitmap", r_bm, 64'h00000020_00000020);
    chk("read_wen", wen_m, 8'h00);
    chk("read_bitmap_hold", bus.rsp_bitmap, 64'h00000020_00000020);
    run(2'b10, 8'd1, 12'd4090);
    chk("init1_w4", mem[4], 32'h80000FFA);
    run(2'b00, 8'd1, 12'd5);
    chk("wrap_status", r_st, 0);
    chk("wrap_ssn", r_ssn, 12'hFFA);
    chk("wrap_w5", mem[5], 32'h00000800);
    run(2'b00, 8'd1, 12'd4089);
    chk("outwin_lat", lat, 4);
    chk("outwin_status", r_st, 1);
    chk("outwin_wen", wen_m, 8'h00);
    chk("outwin_w5", mem[5], 32'h00000800);
    run(2'b00, 8'd7, 12'h010);
    chk("notinit_lat", lat, 4);
    chk("notinit_status", r_st, 2);
    chk("notinit_wen", wen_m, 8'h00);
    chk("notinit_w28", mem[28], 32'h0);
    run(2'b11, 8'd3, 12'h000);
    chk("badcmd_lat", lat, 1);
    chk("badcmd_status", r_st, 3);
    chk("badcmd_en_wen", {en_m, wen_m}, 16'h0);
    run(2'b00, 8'd3, 12'h105);
    chk("dup_status", r_st, 0);
    chk("dup_w13", mem[13], 32'h20);
    run(2'b01, 8'd3, 12'h000);
    chk("dup_read_bitmap", r_bm, 64'h00000020_00000020);
    acc = 0; rsps = 0;
    bus.req_cmd = 2'b01; bus.req_sta = 8'd3; bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.rsp_valid) rsps++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("hold_accepts", acc, 2);
    chk("hold_responses", rsps, 2);
    @(posedge clk); #1;
    bus.req_cmd = 2'b00; bus.req_sta = 8'd3; bus.req_seq = 12'h107; bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_en", bus.mem_tx_in_en, 1);
    chk("midrst_wen", bus.mem_tx_in_wen, 0);
    chk("midrst_ssn", bus.rsp_ssn, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_w13", mem[13], 32'h20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
